// File: rtl/prng_request_arbiter_if.sv
// prng_request_arbiter_if: groups the requester-side and PRNG-core-side signals
// of prng_request_arbiter so they travel as one port.
// slave modport = arbiter view. master modport = requesters plus PRNG core view.
//
// Ports / members:
//   req        [NUM_REQ]          level request per requester
//   req_limit  [NUM_REQ*LIMIT_W]  range bound, slice i = [i*LIMIT_W +: LIMIT_W]
//   ack        [NUM_REQ]          one-hot grant-complete pulse
//   rnd_out    [LIMIT_W]          scaled value, valid while ack != 0
//   rnd_err                       timeout flag qualified by ack
//   seed_load / seed_value[32]    seed reload request (pulse) and its seed
//   busy                          arbiter not idle
//   prng_step / prng_load         one-cycle pulses to the PRNG core
//   prng_seed  [32]               seed presented with prng_load
//   prng_data  [32] / prng_valid  PRNG core result
interface prng_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LIMIT_W = 8
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*LIMIT_W-1:0] req_limit;
  logic [NUM_REQ-1:0]         ack;
  logic [LIMIT_W-1:0]         rnd_out;
  logic                       rnd_err;
  logic                       seed_load;
  logic [31:0]                seed_value;
  logic                       busy;
  logic                       prng_step;
  logic                       prng_load;
  logic [31:0]                prng_seed;
  logic [31:0]                prng_data;
  logic                       prng_valid;

  modport slave (
    input  req, req_limit, seed_load, seed_value, prng_data, prng_valid,
    output ack, rnd_out, rnd_err, busy, prng_step, prng_load, prng_seed
  );

  modport master (
    output req, req_limit, seed_load, seed_value, prng_data, prng_valid,
    input  ack, rnd_out, rnd_err, busy, prng_step, prng_load, prng_seed
  );
endinterface

// File: rtl/prng_request_arbiter.sv
// prng_request_arbiter: round-robin share of one PRNG core among NUM_REQ requesters.
// Latency: req seen in IDLE at cycle n -> prng_step n+1 -> ack n+4 (prng_valid one cycle after step).
// Backpressure: requests are level and held off while busy; WAIT stalls until prng_valid.
//
// Ports:
//   ACLK, ARESET  clock (posedge) and asynchronous active-high reset
//   rif           prng_request_arbiter_if.slave (requests, grants, seed reload, PRNG core side)
// Optional feature macro: PRNG_ARB_TIMEOUT_EN
//   defined   -> WAIT gives up after TIMEOUT cycles and acks with rnd_err=1, rnd_out=0
//   undefined -> WAIT holds indefinitely, rnd_err tied 0
module prng_request_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          LIMIT_W      = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468,
  parameter int          TIMEOUT      = 64
) (
  input logic                   ACLK,
  input logic                   ARESET,
  prng_request_arbiter_if.slave rif
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int PROD_W = 16 + LIMIT_W;

  // Elaboration-time parameter sanity check.
  if (NUM_REQ < 2 || NUM_REQ > 8 || LIMIT_W < 1 || LIMIT_W > 16 ||
      SEED_DEFAULT == 32'd0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("prng_request_arbiter: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_WAIT,
    S_SCALE,
    S_ACK
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [LIMIT_W-1:0]   lim_q, lim_d;
  logic [PROD_W-1:0]    prod_q, prod_d;
  logic [31:0]          seed_q, seed_d;
  logic                 seed_pending_q, seed_pending_d;
  logic [31:0]          prng_seed_q, prng_seed_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [LIMIT_W-1:0]   rnd_out_q, rnd_out_d;
  logic                 busy_q, busy_d;
  logic                 prng_step_q, prng_step_d;
  logic                 prng_load_q, prng_load_d;

  logic                 any_req;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     arb_idx;
  logic [LIMIT_W-1:0]   lim_sel;
  logic [31:0]          seed_eff;

`ifdef PRNG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 rnd_err_q, rnd_err_d;
`endif

  // Only the upper half of the PRNG word feeds the scaler.
  logic unused_prng_lo;
  assign unused_prng_lo = ^rif.prng_data[15:0];

  // Round-robin search: first set request after rr_ptr, wrapping modulo NUM_REQ.
  // The pointer itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    arb_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!any_req && rif.req[arb_idx]) begin
        any_req = 1'b1;
        pick    = arb_idx;
      end
    end
  end

  // Range bound of the selected requester.
  always_comb begin
    lim_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == pick) begin
        lim_sel = rif.req_limit[i*LIMIT_W +: LIMIT_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    win_d          = win_q;
    lim_d          = lim_q;
    prod_d         = prod_q;
    seed_d         = seed_q;
    seed_pending_d = seed_pending_q;
    prng_seed_d    = prng_seed_q;
    ack_d          = '0;
    rnd_out_d      = '0;
    prng_step_d    = 1'b0;
    prng_load_d    = 1'b0;
    seed_eff       = seed_q;
`ifdef PRNG_ARB_TIMEOUT_EN
    wait_cnt_d     = '0;
    rnd_err_d      = 1'b0;
`endif

    // A reload arriving while busy is parked; a later one overwrites it.
    if (rif.seed_load && state_q != S_IDLE) begin
      seed_pending_d = 1'b1;
      seed_d         = rif.seed_value;
    end

    case (state_q)
      S_IDLE: begin
        if (seed_pending_q || rif.seed_load) begin
          // A fresh pulse in IDLE wins over the parked seed value.
          seed_eff       = rif.seed_load ? rif.seed_value : seed_q;
          prng_seed_d    = (seed_eff == 32'd0) ? SEED_DEFAULT : seed_eff;
          prng_load_d    = 1'b1;
          seed_pending_d = 1'b0;
          state_d        = S_LOAD;
        end else if (any_req) begin
          win_d       = pick;
          lim_d       = lim_sel;
          rr_ptr_d    = pick;
          prng_step_d = 1'b1;
          state_d     = S_STEP;
        end
      end

      S_LOAD: state_d = S_IDLE;

      S_STEP: state_d = S_WAIT;

      S_WAIT: begin
        if (rif.prng_valid) begin
          prod_d  = PROD_W'(rif.prng_data[31:16]) * PROD_W'(lim_q);
          state_d = S_SCALE;
        end
`ifdef PRNG_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
          ack_d[win_q] = 1'b1;
          rnd_err_d    = 1'b1;
          state_d      = S_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      // Top LIMIT_W bits of a 16 x LIMIT_W product are always < lim (and 0 for lim 0).
      S_SCALE: begin
        ack_d[win_q] = 1'b1;
        rnd_out_d    = prod_q[PROD_W-1:16];
        state_d      = S_ACK;
      end

      S_ACK: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= PTR_W'(NUM_REQ - 1);
      win_q          <= '0;
      lim_q          <= '0;
      prod_q         <= '0;
      seed_q         <= '0;
      seed_pending_q <= 1'b0;
      prng_seed_q    <= SEED_DEFAULT;
      ack_q          <= '0;
      rnd_out_q      <= '0;
      busy_q         <= 1'b0;
      prng_step_q    <= 1'b0;
      prng_load_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      win_q          <= win_d;
      lim_q          <= lim_d;
      prod_q         <= prod_d;
      seed_q         <= seed_d;
      seed_pending_q <= seed_pending_d;
      prng_seed_q    <= prng_seed_d;
      ack_q          <= ack_d;
      rnd_out_q      <= rnd_out_d;
      busy_q         <= busy_d;
      prng_step_q    <= prng_step_d;
      prng_load_q    <= prng_load_d;
    end
  end

`ifdef PRNG_ARB_TIMEOUT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wait_cnt_q <= '0;
      rnd_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rnd_err_q  <= rnd_err_d;
    end
  end
  assign rif.rnd_err = rnd_err_q;
`else
  assign rif.rnd_err = 1'b0;
`endif

  assign rif.ack       = ack_q;
  assign rif.rnd_out   = rnd_out_q;
  assign rif.busy      = busy_q;
  assign rif.prng_step = prng_step_q;
  assign rif.prng_load = prng_load_q;
  assign rif.prng_seed = prng_seed_q;

endmodule

// File: tb/tb_prng_request_arbiter.sv
// tb_prng_request_arbiter: directed vector table, hand-written corner sequences
// and a randomized run scored against a transaction-level reference model.
module tb_prng_request_arbiter;
  localparam int          NUM_REQ  = 4;
  localparam int          LIMIT_W  = 8;
  localparam int          TIMEOUT  = 64;
  localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  prng_request_arbiter_if #(.NUM_REQ(NUM_REQ), .LIMIT_W(LIMIT_W)) rif ();

  prng_request_arbiter #(
    .NUM_REQ(NUM_REQ), .LIMIT_W(LIMIT_W), .SEED_DEFAULT(SEED_DEF), .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .rif   (rif)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  lim;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_rnd;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_all_lims(input logic [7:0] v);
    for (int i = 0; i < NUM_REQ; i++) rif.req_limit[i*LIMIT_W +: LIMIT_W] = v;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  // One transaction: drive rq, optionally answer the step one cycle later, wait for ack.
  task automatic run_txn(input logic [3:0] rq, input logic [31:0] data, input bit respond,
                         input int budget, output logic [3:0] g_ack, output logic [7:0] g_rnd,
                         output logic g_err, output int lat);
    bit vpend;
    bit got;
    vpend = 1'b0;
    got   = 1'b0;
    g_ack = '0;
    g_rnd = '0;
    g_err = 1'b0;
    lat   = 0;
    rif.req = rq;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      lat++;
      rif.prng_valid = 1'b0;
      if (vpend) begin
        rif.prng_valid = 1'b1;
        rif.prng_data  = data;
        vpend = 1'b0;
      end
      if (respond && rif.prng_step) vpend = 1'b1;
      if (rif.ack != '0) begin
        got   = 1'b1;
        g_ack = rif.ack;
        g_rnd = rif.rnd_out;
        g_err = rif.rnd_err;
      end
    end
    rif.req = '0;
    rif.prng_valid = 1'b0;
    chk("txn_ack_within_budget", got, 1);
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [3:0]  g_ack;
    logic [7:0]  g_rnd;
    logic        g_err;
    int          lat;
    logic [3:0]  rr_order[5];
    int          nack, nstep, t_ack1, t_ack2, t_load, t_step, seen;
    bit          vp, ok;
    // random-run reference model state
    logic [3:0]  req_prev;
    logic [31:0] lim_prev;
    int          last_win, exp_win, vcnt, n_rand_ack, j;
    bit          have_txn, seed_pend;
    logic [7:0]  exp_lim;
    logic [31:0] exp_data, seed_exp, p, r;

    vt[0] = '{4'b0001, 8'd10,  32'h8000_0000, 4'b0001, 8'd5};
    vt[1] = '{4'b0010, 8'd0,   32'hFFFF_FFFF, 4'b0010, 8'd0};
    vt[2] = '{4'b0100, 8'd255, 32'hFFFF_FFFF, 4'b0100, 8'd254};
    vt[3] = '{4'b1000, 8'd1,   32'hFFFF_FFFF, 4'b1000, 8'd0};
    vt[4] = '{4'b0001, 8'd200, 32'h0000_1234, 4'b0001, 8'd0};
    vt[5] = '{4'b0010, 8'd100, 32'h4000_0000, 4'b0010, 8'd25};
    vt[6] = '{4'b0100, 8'd3,   32'hC000_5A5A, 4'b0100, 8'd2};
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rif.req        = '0;
    rif.req_limit  = '0;
    rif.seed_load  = 1'b0;
    rif.seed_value = '0;
    rif.prng_data  = '0;
    rif.prng_valid = 1'b0;
    ARESET = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_ack", rif.ack, 0);
    chk("rst_rnd_out", rif.rnd_out, 0);
    chk("rst_rnd_err", rif.rnd_err, 0);
    chk("rst_busy", rif.busy, 0);
    chk("rst_prng_step", rif.prng_step, 0);
    chk("rst_prng_load", rif.prng_load, 0);
    chk("rst_prng_seed", rif.prng_seed, SEED_DEF);
    ARESET = 1'b0;
    tick();

    // Vector table: single-requester transactions and scaling boundaries
    for (int v = 0; v < 7; v++) begin
      set_all_lims(vt[v].lim);
      run_txn(vt[v].req, vt[v].data, 1'b1, 20, g_ack, g_rnd, g_err, lat);
      chk($sformatf("vec%0d_ack", v), g_ack, vt[v].exp_ack);
      chk($sformatf("vec%0d_rnd", v), g_rnd, vt[v].exp_rnd);
      chk($sformatf("vec%0d_err", v), g_err, 0);
      chk($sformatf("vec%0d_latency", v), lat, 4);
      chk($sformatf("vec%0d_idle_after", v), rif.busy, 0);
    end

    // Round robin with all requesters held
    do_reset();
    set_all_lims(8'd255);
    rif.req = 4'b1111;
    nack = 0; nstep = 0; vp = 1'b0;
    for (int c = 0; c < 100 && nack < 5; c++) begin
      tick();
      rif.prng_valid = 1'b0;
      if (vp) begin rif.prng_valid = 1'b1; vp = 1'b0; end
      if (rif.prng_step) begin nstep++; vp = 1'b1; rif.prng_data = $urandom; end
      if (rif.ack != '0) begin
        chk($sformatf("rr_order%0d", nack), rif.ack, rr_order[nack]);
        chk($sformatf("rr_steps_at_ack%0d", nack), nstep, nack + 1);
        nack++;
        if (nack == 5) rif.req = '0;
      end
    end
    chk("rr_ack_count", nack, 5);
    rif.prng_valid = 1'b0;
    tick();
    tick();

    // Zero seed reload while in WAIT, with another request pending
    set_all_lims(8'd7);
    rif.req = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      if (rif.prng_step) ok = 1'b1;
    end
    chk("seed_first_step", ok, 1);
    tick();
    rif.seed_load  = 1'b1;
    rif.seed_value = 32'd0;
    rif.req        = 4'b0110;
    rif.prng_valid = 1'b1;
    rif.prng_data  = 32'h1234_5678;
    tick();
    rif.seed_load  = 1'b0;
    rif.prng_valid = 1'b0;
    t_ack1 = -1; t_ack2 = -1; t_load = -1; t_step = -1; vp = 1'b0;
    for (int c = 0; c < 40 && t_ack2 < 0; c++) begin
      tick();
      rif.prng_valid = 1'b0;
      if (vp) begin rif.prng_valid = 1'b1; vp = 1'b0; end
      if (rif.prng_load) begin
        t_load = c;
        chk("seed_zero_substituted", rif.prng_seed, SEED_DEF);
      end
      if (rif.prng_step) begin t_step = c; vp = 1'b1; end
      if (rif.ack != '0) begin
        if (t_ack1 < 0) begin
          t_ack1 = c;
          chk("seed_first_ack", rif.ack, 4'b0010);
          rif.req[1] = 1'b0;
        end else begin
          t_ack2 = c;
          chk("seed_second_ack", rif.ack, 4'b0100);
          rif.req = '0;
        end
      end
    end
    chk("seed_load_after_ack", t_load - t_ack1, 2);
    chk("seed_step_after_load", t_step - t_load, 2);
    chk("seed_second_ack_seen", (t_ack2 >= 0), 1);
    rif.prng_valid = 1'b0;
    tick();

    // Reset asserted in WAIT aborts the transaction
    rif.req = 4'b0100;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      if (rif.prng_step) ok = 1'b1;
    end
    chk("abort_step_seen", ok, 1);
    tick();
    ARESET = 1'b1;
    #1;
    chk("abort_busy_now", rif.busy, 0);
    chk("abort_ack_now", rif.ack, 0);
    rif.req = '0;
    tick();
    tick();
    ARESET = 1'b0;
    rif.prng_valid = 1'b1;
    rif.prng_data  = 32'hFFFF_0000;
    tick();
    rif.prng_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rif.ack != '0 || rif.busy || rif.prng_load || rif.prng_step) seen++;
    end
    chk("abort_quiet_after", seen, 0);
    set_all_lims(8'd255);
    run_txn(4'b1111, 32'h8000_0000, 1'b1, 20, g_ack, g_rnd, g_err, lat);
    chk("abort_next_grant_req0", g_ack, 4'b0001);
    chk("abort_next_rnd", g_rnd, 8'd127);
    chk("abort_next_latency", lat, 4);

`ifdef PRNG_ARB_TIMEOUT_EN
    // No prng_valid at all: timeout path
    run_txn(4'b0001, 32'd0, 1'b0, TIMEOUT + 20, g_ack, g_rnd, g_err, lat);
    chk("timeout_ack", g_ack, 4'b0001);
    chk("timeout_latency", lat, TIMEOUT + 3);
    chk("timeout_err", g_err, 1);
    chk("timeout_rnd", g_rnd, 0);
`endif

    // Randomized run against a transaction-level reference model
    do_reset();
    rif.req = '0;
    req_prev = '0; lim_prev = rif.req_limit;
    last_win = NUM_REQ - 1; have_txn = 1'b0; seed_pend = 1'b0; seed_exp = '0;
    vcnt = 0; n_rand_ack = 0; exp_win = 0; exp_lim = '0; exp_data = '0;
    for (int c = 0; c < 3300; c++) begin
      tick();
      // observe
      if (rif.prng_load) begin
        chk("rand_load_was_pending", seed_pend, 1);
        chk("rand_load_seed", rif.prng_seed, (seed_exp == 32'd0) ? SEED_DEF : seed_exp);
        seed_pend = 1'b0;
      end
      if (rif.prng_step) begin
        chk("rand_one_step_per_ack", have_txn, 0);
        exp_win = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = (last_win + k) % NUM_REQ;
          if (exp_win < 0 && req_prev[j]) exp_win = j;
        end
        chk("rand_step_had_request", (exp_win >= 0), 1);
        if (exp_win >= 0) begin
          last_win = exp_win;
          exp_lim  = lim_prev[exp_win*LIMIT_W +: LIMIT_W];
        end
        have_txn = 1'b1;
        vcnt = $urandom_range(1, 3) + 1;
      end
      if (rif.ack != '0) begin
        chk("rand_ack_had_txn", have_txn, 1);
        if (exp_win >= 0) begin
          p = 32'(exp_data[31:16]) * 32'(exp_lim);
          r = p >> 16;
          chk("rand_ack_winner", rif.ack, 32'(1) << exp_win);
          chk("rand_rnd_out", rif.rnd_out, r);
          if ($urandom_range(0, 1) == 0) rif.req[exp_win] = 1'b0;
        end
        chk("rand_rnd_err", rif.rnd_err, 0);
        have_txn = 1'b0;
        n_rand_ack++;
      end else begin
        chk("rand_rnd_zero_without_ack", rif.rnd_out, 0);
      end
      // drive PRNG core response (plus stray valids while nothing is outstanding)
      rif.prng_valid = 1'b0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          exp_data = $urandom;
          rif.prng_data  = exp_data;
          rif.prng_valid = 1'b1;
        end
      end else if (!have_txn && $urandom_range(0, 7) == 0) begin
        rif.prng_data  = $urandom;
        rif.prng_valid = 1'b1;
      end
      // drive requesters and seed reloads
      rif.seed_load = 1'b0;
      if (c < 3000) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!rif.req[i] && $urandom_range(0, 3) == 0) begin
            rif.req[i] = 1'b1;
            rif.req_limit[i*LIMIT_W +: LIMIT_W] = 8'($urandom_range(0, 255));
          end
        end
        if ($urandom_range(0, 39) == 0) begin
          seed_exp = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          rif.seed_load  = 1'b1;
          rif.seed_value = seed_exp;
          seed_pend = 1'b1;
        end
      end else begin
        rif.req = '0;
      end
      req_prev = rif.req;
      lim_prev = rif.req_limit;
    end
    chk("rand_drained", {have_txn, seed_pend}, 0);
    chk("rand_idle_at_end", rif.busy, 0);
    chk("rand_enough_acks", (n_rand_ack > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prng_request_arbiter.md
Name: prng_request_arbiter

Overview:
- Shares the single AXI-lite pseudo-random number generator core among NUM_REQ game-logic requesters, such as the enemy spawner, power-up dropper and scroll jitter.
- Arbitrates round-robin, steps the PRNG once per grant and captures its 32-bit output.
- Scales the upper 16 bits into the range [0, limit) requested by the winner.
- Sequences seed reloads into the core.
- Sits between the game FSMs and the PRNG core inside the PL.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LIMIT_W, 8, width of per-requester range bound and returned value (1..16)
SEED_DEFAULT, 32'hACE1_2468, seed substituted when a zero seed is requested (must be nonzero)
TIMEOUT, 64, cycles to wait for prng_valid before error (optional feature only)

Ports:
ACLK  in  1  system clock, all logic posedge
ARESET  in  1  asynchronous, active-high reset
req  in  NUM_REQ  request per requester, level
req_limit  in  NUM_REQ*LIMIT_W  range bound per requester; slice i = [i*LIMIT_W +: LIMIT_W]
ack  out  NUM_REQ  one-cycle grant-complete pulse, one-hot
rnd_out  out  LIMIT_W  scaled random value; valid only while any ack bit is high
rnd_err  out  1  timeout flag qualified by ack; tied 0 when the feature is disabled
seed_load  in  1  seed reload request, pulse
seed_value  in  32  seed sampled with seed_load
busy  out  1  high in every state except IDLE
prng_step  out  1  one-cycle pulse to advance the PRNG core
prng_load  out  1  one-cycle pulse to load prng_seed into the core
prng_seed  out  32  seed to core, stable while prng_load is high
prng_data  in  32  PRNG output
prng_valid  in  1  prng_data valid, at least one cycle after prng_step

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - ack=0, rnd_out=0, rnd_err=0, busy=0, prng_step=0, prng_load=0.
  - prng_seed=SEED_DEFAULT; seed_pending=0.
  - Assertion mid-operation aborts the transaction: no ack and no load is issued afterwards.
- States: IDLE, LOAD, STEP, WAIT, SCALE, ACK.
- IDLE:
  - If seed_pending or seed_load: go to LOAD. The seed has priority over requests.
  - Else if any req: select the first set bit searching from rr_ptr+1 with modulo-NUM_REQ wrap. Latch its index (win) and req_limit slice (lim), update rr_ptr=win, go to STEP.
- LOAD (1 cycle):
  - prng_load=1; prng_seed = (latched seed == 0) ? SEED_DEFAULT : latched seed.
  - Clear seed_pending; go to IDLE.
- STEP (1 cycle): prng_step=1; go to WAIT.
- WAIT:
  - On prng_valid, register prod = prng_data[31:16] * lim (16+LIMIT_W bits) and go to SCALE.
  - Otherwise stay in WAIT.
- SCALE (1 cycle): rnd_q = prod >> 16; guaranteed < lim; lim==0 yields 0.
- ACK (1 cycle): ack[win]=1, rnd_out=rnd_q; go to IDLE.
- Outputs are registered. rnd_out and rnd_err return to 0 when ack is low.
- Latency with prng_valid one cycle after the step:
  - req seen in IDLE at cycle n; prng_step at n+1; prng_valid captured at n+2; ack at n+4.
  - Next arbitration at n+5.
- Request rules:
  - A request is committed once latched; dropping req afterwards does not cancel it.
  - req still high in the cycle after its ack counts as a new request and is arbitrated normally, behind other pending requesters.
- seed_load while busy: seed_pending=1 and seed_value is latched. A later seed_load before service overwrites the latched value. It is served at the next IDLE, ahead of requests.
- Simultaneous seed_load and req in IDLE: LOAD first, then the request arbitrates in the following IDLE.
- prng_valid outside WAIT is ignored.

Optional Feature:
PRNG_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT. If prng_valid is not seen after TIMEOUT cycles, go directly to ACK with rnd_out=0 and rnd_err=1.
  - The counter clears on leaving WAIT.
- Undefined: no counter; WAIT holds indefinitely; rnd_err is constant 0.

Test Plan:
- Reset, then req=4'b0001, limit0=8'd10, prng_data=32'h8000_0000 valid 1 cycle after step -> ack=4'b0001 four cycles after req, rnd_out=5, rnd_err=0.
- req=4'b1111 held, all limits 8'd255 -> grants in order 0,1,2,3,0 with no requester granted twice before the others; exactly one prng_step per ack.
- seed_load with seed_value=0 while in WAIT -> after the ack, LOAD with prng_load=1 and prng_seed=32'hACE1_2468; a pending req is granted after the load.
- limit=0 with prng_data=32'hFFFF_FFFF -> rnd_out=0; limit=8'd255 with the same data -> rnd_out=254.
- ARESET asserted during WAIT -> ack stays 0, busy=0 immediately, later prng_valid ignored; the next req is granted normally starting from requester 0.
- PRNG_ARB_TIMEOUT_EN defined, prng_valid never asserted -> ack after TIMEOUT+3 cycles from req, with rnd_err=1 and rnd_out=0.
